// File: rtl/alu_top.sv
// 8-bit unsigned ALU (add/sub/mul/div) with one registered 16-bit result.
// Optional feature macro: ALU_DIV_EN enables the restoring-array divider.
module alu_top (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  input  logic [1:0]  op_sel,
  output logic [15:0] result
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  function automatic logic [15:0] f_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum   = {1'b0, a} + {1'b0, b};
    f_add = {7'b0, sum};
  endfunction

  function automatic logic [15:0] f_sub(input logic [7:0] a, input logic [7:0] b);
    f_sub = {8'b0, a} - {8'b0, b};
  endfunction

  // Shift-and-add array: one partial product per bit of b.
  function automatic logic [15:0] f_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] acc;
    acc = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc + ({8'b0, a} << i);
    end
    f_mul = acc;
  endfunction

`ifdef ALU_DIV_EN
  // Restoring array, MSB first. With b == 0 every trial subtraction succeeds,
  // which yields quotient 8'hFF and remainder a without special-casing.
  function automatic logic [15:0] f_div(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] rem;
    logic [7:0] quo;
    logic [8:0] shifted;
    logic [9:0] diff;
    rem = 8'h00;
    quo = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      shifted = {rem, a[i]};
      diff    = {1'b0, shifted} - {2'b00, b};
      if (!diff[9]) begin
        quo[i] = 1'b1;
        rem    = diff[7:0];
      end else begin
        quo[i] = 1'b0;
        rem    = shifted[7:0];
      end
    end
    f_div = {rem, quo};
  endfunction
`endif

  logic [15:0] w_add;
  logic [15:0] w_sub;
  logic [15:0] w_mul;
  logic [15:0] w_div;
  logic [15:0] w_mux;
  logic [15:0] r_result_p0;

  assign w_add = f_add(A, B);
  assign w_sub = f_sub(A, B);
  assign w_mul = f_mul(A, B);
`ifdef ALU_DIV_EN
  assign w_div = f_div(A, B);
`else
  assign w_div = 16'h0000;
`endif

  always_comb begin
    w_mux = 16'h0000;
    unique case (op_sel)
      OP_ADD:  w_mux = w_add;
      OP_SUB:  w_mux = w_sub;
      OP_MUL:  w_mux = w_mul;
      OP_DIV:  w_mux = w_div;
      default: w_mux = 16'h0000;
    endcase
  end

  // Stage p0: output register; reset wins over the operation sampled this edge.
  always_ff @(posedge clk) begin
    if (reset) r_result_p0 <= 16'h0000;
    else       r_result_p0 <= w_mux;
  end

  assign result = r_result_p0;

endmodule

// File: tb/tb_alu_top.sv
// Directed self-checking bench for alu_top; DIV expectations follow ALU_DIV_EN.
module tb_alu_top;

  logic        clk;
  logic        reset;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [1:0]  op_sel;
  logic [15:0] result;

  int n_checks = 0;
  int n_fails  = 0;

`ifdef ALU_DIV_EN
  localparam logic [15:0] EXP_DIV_4_2 = 16'h0002;
  localparam logic [15:0] EXP_DIV_7_3 = 16'h0102;
  localparam logic [15:0] EXP_DIV_7_0 = 16'h07FF;
  localparam logic [15:0] EXP_DIV_FF_10 = 16'h0F0F;
`else
  localparam logic [15:0] EXP_DIV_4_2 = 16'h0000;
  localparam logic [15:0] EXP_DIV_7_3 = 16'h0000;
  localparam logic [15:0] EXP_DIV_7_0 = 16'h0000;
  localparam logic [15:0] EXP_DIV_FF_10 = 16'h0000;
`endif

  alu_top dut (
    .clk    (clk),
    .reset  (reset),
    .A      (A),
    .B      (B),
    .op_sel (op_sel),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] exp);
    n_checks++;
    assert (result === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, result, exp);
    end
  endtask

  task automatic step(input logic rst, input logic [7:0] a, input logic [7:0] b,
                      input logic [1:0] op, input logic [15:0] exp, input string tag);
    reset  = rst;
    A      = a;
    B      = b;
    op_sel = op;
    @(posedge clk);
    #1;
    check(tag, exp);
  endtask

  initial begin
    reset = 1'b1; A = 8'h00; B = 8'h00; op_sel = 2'b00;
    @(negedge clk);

    step(1'b1, 8'hFF, 8'hFF, 2'b10, 16'h0000, "reset");
    step(1'b0, 8'hFF, 8'hFF, 2'b10, 16'hFE01, "reset_release");

    step(1'b0, 8'hAA, 8'h55, 2'b00, 16'h00FF, "add_aa_55");
    step(1'b0, 8'hFF, 8'h01, 2'b00, 16'h0100, "add_carry");
    step(1'b0, 8'hFF, 8'hFF, 2'b00, 16'h01FE, "add_max");

    step(1'b0, 8'hAA, 8'h55, 2'b01, 16'h0055, "sub_aa_55");
    step(1'b0, 8'h01, 8'h02, 2'b01, 16'hFFFF, "sub_borrow");
    step(1'b0, 8'h00, 8'hFF, 2'b01, 16'hFF01, "sub_0_ff");
    step(1'b0, 8'h42, 8'h42, 2'b01, 16'h0000, "sub_equal");

    step(1'b0, 8'h03, 8'h02, 2'b10, 16'h0006, "mul_3_2");
    step(1'b0, 8'hFF, 8'hFF, 2'b10, 16'hFE01, "mul_max");
    step(1'b0, 8'h80, 8'h00, 2'b10, 16'h0000, "mul_zero");

    step(1'b0, 8'h04, 8'h02, 2'b11, EXP_DIV_4_2, "div_4_2");
    step(1'b0, 8'h07, 8'h03, 2'b11, EXP_DIV_7_3, "div_7_3");
    step(1'b0, 8'h07, 8'h00, 2'b11, EXP_DIV_7_0, "div_by_zero");
    step(1'b0, 8'hFF, 8'h10, 2'b11, EXP_DIV_FF_10, "div_ff_10");

    // Inputs changing between edges must not disturb the registered result.
    step(1'b0, 8'h10, 8'h20, 2'b00, 16'h0030, "hold_before");
    A = 8'hFF; B = 8'hFF; op_sel = 2'b10;
    #3;
    check("hold_between_edges", 16'h0030);
    A = 8'h10; B = 8'h20; op_sel = 2'b01;
    @(posedge clk);
    #1;
    check("hold_next_edge", 16'hFFF0);

    // Back-to-back op changes with a one-edge reset in the middle.
    step(1'b0, 8'h12, 8'h34, 2'b00, 16'h0046, "b2b_add");
    step(1'b0, 8'h34, 8'h12, 2'b01, 16'h0022, "b2b_sub");
    step(1'b1, 8'h10, 8'h10, 2'b10, 16'h0000, "b2b_reset");
    step(1'b0, 8'h10, 8'h10, 2'b10, 16'h0100, "b2b_resume_mul");
    step(1'b0, 8'h09, 8'h04, 2'b11,
`ifdef ALU_DIV_EN
         16'h0102,
`else
         16'h0000,
`endif
         "b2b_div");
    step(1'b0, 8'h80, 8'h80, 2'b00, 16'h0100, "b2b_add_carry");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
